// File: rtl/incond_pkg.sv
// Shared constants and types for the board input conditioner.
// Counter widths come from the debounce length so that a board build and a sim build size themselves.
package incond_pkg;

    localparam int DEBOUNCE_BOARD = 500000;
    localparam int DEBOUNCE_SIM   = 4;
    localparam int N_SW_DE10      = 10;
    localparam int N_KEY_DE10     = 2;

    // A count of 0..cycles-1 needs $clog2(cycles) bits; never allow a zero-width counter.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    typedef logic [cnt_width(DEBOUNCE_BOARD)-1:0] cnt_board_t;
    typedef logic [cnt_width(DEBOUNCE_SIM)-1:0]   cnt_sim_t;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_t;

endpackage

// File: rtl/debounce_bit.sv
// One-bit synchronizer + debouncer: clean follows the synchronized input after DEBOUNCE_CYCLES stable edges.
// Raw-to-clean latency is DEBOUNCE_CYCLES+2 edges; rise/fall pulses are registered alongside clean.
module debounce_bit
    import incond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          clean_q;
    logic          clean_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    edge_t         edge_d;

    // The counter only runs while the input disagrees with clean, so it cannot pass CNT_LAST.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        edge_d  = EDGE_NONE;
        if (s2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = s2_q;
                edge_d  = s2_q ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = (edge_d == EDGE_RISE);
        fall_d = (edge_d == EDGE_FALL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            clean_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Board SW/KEY front-end: synchronizes and debounces inputs, gives active-high key levels and press/release pulses.
// INCOND_SW_DEBOUNCE_EN selects debounced switches; otherwise switches are only double-flopped (2-edge latency).
module input_conditioner
    import incond_pkg::*;
#(
    parameter int N_SW            = N_SW_DE10,
    parameter int N_KEY           = N_KEY_DE10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_BOARD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_KEY-1:0] key_raw_n,
    output logic [N_SW-1:0]  sw_clean,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release
);

    logic [N_KEY-1:0] key_clean_n;
    logic [N_KEY-1:0] key_rise_n;
    logic [N_KEY-1:0] key_fall_n;

    // Keys are debounced in raw (active-low) polarity so their flops reset to "released";
    // a falling raw edge is therefore a press.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b1)
        ) u_key_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (key_raw_n[i]),
            .clean_o (key_clean_n[i]),
            .rise_o  (key_rise_n[i]),
            .fall_o  (key_fall_n[i])
        );
    end

    assign key_level   = ~key_clean_n;
    assign key_press   = key_fall_n;
    assign key_release = key_rise_n;

`ifdef INCOND_SW_DEBOUNCE_EN
    logic [N_SW-1:0] sw_rise_unused;
    logic [N_SW-1:0] sw_fall_unused;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0)
        ) u_sw_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (sw_raw[i]),
            .clean_o (sw_clean[i]),
            .rise_o  (sw_rise_unused[i]),
            .fall_o  (sw_fall_unused[i])
        );
    end
`else
    logic [N_SW-1:0] sw_s1_q;
    logic [N_SW-1:0] sw_s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_raw;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign sw_clean = sw_s2_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized bench for input_conditioner with a sliding-window reference model.
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int NB = 12;
`ifdef INCOND_SW_DEBOUNCE_EN
    localparam bit SW_DEB = 1'b1;
`else
    localparam bit SW_DEB = 1'b0;
`endif
    localparam int SW_EDGE = SW_DEB ? D + 1 : 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] sw_raw;
    logic [1:0] key_raw_n;
    logic [9:0] sw_clean;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    input_conditioner #(
        .N_SW            (10),
        .N_KEY           (2),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_raw      (sw_raw),
        .key_raw_n   (key_raw_n),
        .sw_clean    (sw_clean),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Inputs in active-high level polarity {keys, switches}; hist[D+1] is the value at the current edge.
    logic [NB-1:0] hist [0:D+1];
    logic [NB-1:0] m_clean;
    logic [1:0]    m_press;
    logic [1:0]    m_rel;

    // A bit settles to a value once the synchronized input (two edges stale) has shown it for D edges running.
    task automatic model_edge();
        logic [NB-1:0] nxt;
        logic          stable;
        if (!rst_n) begin
            for (int i = 0; i <= D + 1; i++) hist[i] = '0;
            m_clean = '0;
            m_press = '0;
            m_rel   = '0;
            return;
        end
        for (int i = 0; i <= D; i++) hist[i] = hist[i+1];
        hist[D+1] = {~key_raw_n, sw_raw};
        nxt = m_clean;
        for (int b = 0; b < NB; b++) begin
            if (b < 10 && !SW_DEB) begin
                nxt[b] = hist[D][b];
            end else begin
                stable = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[j][b] != hist[D-1][b]) stable = 1'b0;
                if (stable) nxt[b] = hist[D-1][b];
            end
        end
        m_press = nxt[11:10] & ~m_clean[11:10];
        m_rel   = ~nxt[11:10] & m_clean[11:10];
        m_clean = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic [9:0] sw, input logic [1:0] kn);
        rst_n     = r;
        sw_raw    = sw;
        key_raw_n = kn;
        @(posedge clk);
        model_edge();
        #1;
        chk("sw_clean", 32'(sw_clean), 32'(m_clean[9:0]));
        chk("key_level", 32'(key_level), 32'(m_clean[11:10]));
        chk("key_press", 32'(key_press), 32'(m_press));
        chk("key_release", 32'(key_release), 32'(m_rel));
        chk("press_release_excl", 32'(key_press & key_release), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 10'h000, 2'b11);
    endtask

    // Pulse sw_raw[0] high for len edges and count the cycles sw_clean[0] reads high.
    task automatic glitch(input int len, output int hi);
        hi = 0;
        for (int i = 0; i < len; i++) begin
            tick(1'b1, 10'h001, 2'b11);
            hi += int'(sw_clean[0]);
        end
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, 10'h000, 2'b11);
            hi += int'(sw_clean[0]);
        end
    endtask

    initial begin
        int first;
        int cnt;
        int at;
        int hi;
        int seg;
        logic [9:0] rs;
        logic [1:0] rk;
        logic       seen;

        // Reset with everything asserted on the raw inputs.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 10'h3FF, 2'b00);
            chk("reset_outputs", 32'({sw_clean, key_level, key_press, key_release}), 32'd0);
        end
        tick(1'b1, 10'h3FF, 2'b00);
        chk("first_cycle_pulses", 32'({key_press, key_release}), 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b1, 10'h3FF, 2'b00);
        idle(12);

        // Switch step 000 -> 101.
        for (int e = 0; e < 8; e++) begin
            tick(1'b1, 10'b101, 2'b11);
            if (e == SW_EDGE - 1) chk("sw_step_before", 32'(sw_clean[2:0]), 32'd0);
            if (e == SW_EDGE)     chk("sw_step_at", 32'(sw_clean[2:0]), 32'b101);
        end
        idle(10);

        glitch(3, hi);
        chk("glitch3_hi_cycles", 32'(hi), SW_DEB ? 32'd0 : 32'd3);
        glitch(6, hi);
        chk("glitch6_hi_cycles", 32'(hi), 32'd6);
        glitch(1, hi);
        chk("glitch1_hi_cycles", 32'(hi), SW_DEB ? 32'd0 : 32'd1);

        // KEY0 press held 12 cycles, then released.
        first = -1; cnt = 0; at = -1;
        for (int e = 0; e < 12; e++) begin
            tick(1'b1, 10'h000, 2'b10);
            if (key_level[0] && first < 0) first = e;
            if (key_press[0]) begin cnt++; at = e; end
        end
        chk("key0_level_rise_edge", 32'(first), 32'd5);
        chk("key0_press_count", 32'(cnt), 32'd1);
        chk("key0_press_edge", 32'(at), 32'd5);
        first = -1; cnt = 0; at = -1;
        for (int e = 0; e < 12; e++) begin
            tick(1'b1, 10'h000, 2'b11);
            if (!key_level[0] && first < 0) first = e;
            if (key_release[0]) begin cnt++; at = e; end
        end
        chk("key0_level_fall_edge", 32'(first), 32'd5);
        chk("key0_release_count", 32'(cnt), 32'd1);
        chk("key0_release_edge", 32'(at), 32'd5);

        // Both keys together.
        for (int e = 0; e < 8; e++) begin
            tick(1'b1, 10'h000, 2'b00);
            if (e == 4) chk("both_press_early", 32'(key_press), 32'd0);
            if (e == 5) chk("both_press_same_cycle", 32'(key_press), 32'b11);
        end
        idle(10);

        // KEY1 pressed, reset mid-count, key held through reset release.
        seen = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick(1'b1, 10'h000, 2'b01);
            seen |= key_press[1];
        end
        tick(1'b0, 10'h000, 2'b01);
        seen |= key_press[1];
        chk("no_press_before_reset", 32'(seen), 32'd0);
        at = -1;
        for (int e = 0; e < 10; e++) begin
            tick(1'b1, 10'h000, 2'b01);
            if (key_press[1] && at < 0) at = e;
        end
        chk("key1_press_after_reset", 32'(at), 32'd5);
        idle(10);

        // Randomized hold segments with occasional resets.
        seg = 0; rs = '0; rk = 2'b11;
        for (int c = 0; c < 600; c++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 8);
                rs  = 10'($urandom);
                rk  = 2'($urandom);
            end
            seg--;
            tick(($urandom_range(0, 60) != 0), rs, rk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
